// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: code RAM address/data, downstream stall, execute
// redirect, and the IF/ID register outputs presented to decode.
interface inst_fetch_if;
    logic [31:0] inst_addr;
    logic [31:0] inst_in;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] fetch_cnt;

    // fetch stage side
    modport master (
        output inst_addr, if_valid, if_inst, if_pc, if_pc4, fetch_cnt,
        input  inst_in, stall, redirect_valid, redirect_target
    );

    // code RAM / pipeline environment side
    modport slave (
        input  inst_addr, if_valid, if_inst, if_pc, if_pc4, fetch_cnt,
        output inst_in, stall, redirect_valid, redirect_target
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: program counter, combinational code RAM address,
// IF/ID register with valid flag, stall hold and redirect flush.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);
    logic [31:0] pc;
    logic [31:0] if_inst_q;
    logic [31:0] if_pc_q;
    logic [31:0] fetch_cnt_q;
    logic        if_valid_q;
    logic        unused_target_lsb;

    // target is always word aligned; the low bits are dropped on purpose
    assign unused_target_lsb = &{1'b0, bus.redirect_target[1:0]};

    // PC and IF/ID update; reset > redirect > stall > advance
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_inst_q   <= 32'h0;
            if_pc_q     <= 32'h0;
            fetch_cnt_q <= 32'h0;
        end else if (bus.redirect_valid) begin
            // flush the fetched slot into a NOP bubble; if_pc keeps its value
            pc         <= {bus.redirect_target[31:2], 2'b00};
            if_valid_q <= 1'b0;
            if_inst_q  <= 32'h0;
        end else if (!bus.stall) begin
            pc          <= pc + 32'd4;
            if_valid_q  <= 1'b1;
            if_inst_q   <= bus.inst_in;
            if_pc_q     <= pc;
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign bus.inst_addr = pc;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_pc4    = if_pc_q + 32'd4;
    assign bus.fetch_cnt = fetch_cnt_q;
endmodule
